// File: rtl/forwarding_hazard_ctrl.sv
// forwarding_hazard_ctrl: EX-stage forwarding selects plus load-use/branch stall and debug halt sequencing
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_ifid_rs/i_ifid_rt, i_id_branch            : consumer instruction in ID
//   i_idex_rd/_regwrite/_memread                : producer in EX
//   i_exmem_rd/_regwrite                        : producer in MEM
//   i_halt_req (level), i_step (pulse)          : debug control
//   o_corto_register_A/B                        : registered ALU operand selects (001=EX/MEM, 010=MEM/WB, else ID/EX)
//   o_stall, o_flush_idex, o_halted             : pipeline control
//   o_stall_count                               : saturating count of bubble cycles
module forwarding_hazard_ctrl #(
  parameter int BITS_REGS          = 5,
  parameter int BITS_CORTOCIRCUITO = 3,
  parameter int BITS_COUNT         = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [BITS_REGS-1:0]          i_ifid_rs,
  input  logic [BITS_REGS-1:0]          i_ifid_rt,
  input  logic                          i_id_branch,
  input  logic [BITS_REGS-1:0]          i_idex_rd,
  input  logic                          i_idex_regwrite,
  input  logic                          i_idex_memread,
  input  logic [BITS_REGS-1:0]          i_exmem_rd,
  input  logic                          i_exmem_regwrite,
  input  logic                          i_halt_req,
  input  logic                          i_step,
  output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_A,
  output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_B,
  output logic                          o_stall,
  output logic                          o_flush_idex,
  output logic                          o_halted,
  output logic [BITS_COUNT-1:0]         o_stall_count
);
  localparam logic [BITS_CORTOCIRCUITO-1:0] FW_ID    = '0;
  localparam logic [BITS_CORTOCIRCUITO-1:0] FW_EXMEM = BITS_CORTOCIRCUITO'(1);
  localparam logic [BITS_CORTOCIRCUITO-1:0] FW_MEMWB = BITS_CORTOCIRCUITO'(2);
  typedef enum logic [1:0] {RUN, BSTALL, HALT, STEP} state_t;
  state_t                          state_q, state_d;
  logic [1:0]                      cnt_q, cnt_d;
  logic [BITS_CORTOCIRCUITO-1:0]   sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [BITS_COUNT-1:0]           count_q, count_d;
  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic load_haz, br_haz, br_long, hazard;
  logic [BITS_CORTOCIRCUITO-1:0]   next_a, next_b;
  // r0 is hardwired, so a producer targeting it never forwards or stalls
  assign ex_rs  = i_idex_regwrite  && i_idex_rd  != '0 && i_idex_rd  == i_ifid_rs;
  assign ex_rt  = i_idex_regwrite  && i_idex_rd  != '0 && i_idex_rd  == i_ifid_rt;
  assign mem_rs = i_exmem_regwrite && i_exmem_rd != '0 && i_exmem_rd == i_ifid_rs;
  assign mem_rt = i_exmem_regwrite && i_exmem_rd != '0 && i_exmem_rd == i_ifid_rt;
  assign next_a = ex_rs ? FW_EXMEM : mem_rs ? FW_MEMWB : FW_ID;
  assign next_b = ex_rt ? FW_EXMEM : mem_rt ? FW_MEMWB : FW_ID;
  assign load_haz = i_idex_memread && (ex_rs || ex_rt);
  // branches compare in ID, so any in-flight producer stalls; one still in EX needs two cycles
  assign br_haz   = i_id_branch && (ex_rs || ex_rt || mem_rs || mem_rt);
  assign br_long  = i_id_branch && (ex_rs || ex_rt);
  assign hazard   = load_haz || br_haz;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_a_d      = sel_a_q;
    sel_b_d      = sel_b_q;
    o_stall      = 1'b0;
    o_flush_idex = 1'b0;
    case (state_q)
      RUN, STEP: begin
        if (hazard) begin
          o_stall      = 1'b1;
          o_flush_idex = 1'b1;
          sel_a_d      = FW_ID;
          sel_b_d      = FW_ID;
          cnt_d        = br_long ? 2'd1 : cnt_q;
          // a pending halt waits for the bubble; a step returns to HALT afterwards
          state_d      = br_long ? BSTALL : (state_q == STEP && i_halt_req) ? HALT : RUN;
        end else begin
          sel_a_d = next_a;
          sel_b_d = next_b;
          state_d = i_halt_req ? HALT : RUN;
        end
      end
      BSTALL: begin
        o_stall      = 1'b1;
        o_flush_idex = 1'b1;
        sel_a_d      = FW_ID;
        sel_b_d      = FW_ID;
        cnt_d        = cnt_q - 2'd1;
        state_d      = (cnt_d == 2'd0) ? RUN : BSTALL;
      end
      default: begin
        o_stall = 1'b1;
        state_d = i_step ? STEP : i_halt_req ? HALT : RUN;
      end
    endcase
  end
  assign count_d = (o_flush_idex && count_q != '1) ? count_q + BITS_COUNT'(1) : count_q;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sel_a_q <= FW_ID;
      sel_b_q <= FW_ID;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      count_q <= count_d;
    end
  end
  assign o_corto_register_A = sel_a_q;
  assign o_corto_register_B = sel_b_q;
  assign o_halted           = state_q == HALT;
  assign o_stall_count      = count_q;
endmodule

// File: tb/tb_forwarding_hazard_ctrl.sv
// tb_forwarding_hazard_ctrl: scoreboard bench for forwarding selects, stalls and halt/step
module tb_forwarding_hazard_ctrl;
  logic i_clk, i_reset;
  logic [4:0] i_ifid_rs, i_ifid_rt, i_idex_rd, i_exmem_rd;
  logic i_id_branch, i_idex_regwrite, i_idex_memread, i_exmem_regwrite, i_halt_req, i_step;
  logic [2:0] o_corto_register_A, o_corto_register_B;
  logic o_stall, o_flush_idex, o_halted;
  logic [31:0] o_stall_count;
  logic [40:0] obs;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    string name;
    logic [4:0] rs, rt, idrd, exrd;
    logic br, idwr, idmr, exwr, halt, step;
    logic [40:0] v;
  } row_t;
  typedef struct {
    string name;
    logic [40:0] v;
  } exp_t;
  row_t stq[$];
  exp_t sb[$];
  forwarding_hazard_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt), .i_id_branch(i_id_branch),
    .i_idex_rd(i_idex_rd), .i_idex_regwrite(i_idex_regwrite), .i_idex_memread(i_idex_memread),
    .i_exmem_rd(i_exmem_rd), .i_exmem_regwrite(i_exmem_regwrite),
    .i_halt_req(i_halt_req), .i_step(i_step),
    .o_corto_register_A(o_corto_register_A), .o_corto_register_B(o_corto_register_B),
    .o_stall(o_stall), .o_flush_idex(o_flush_idex), .o_halted(o_halted),
    .o_stall_count(o_stall_count)
  );
  assign obs = {o_stall, o_flush_idex, o_halted, o_corto_register_A, o_corto_register_B, o_stall_count};
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic add(input string n, input logic [4:0] rs, rt, input logic br,
                     input logic [4:0] idrd, input logic idwr, idmr,
                     input logic [4:0] exrd, input logic exwr, halt, step,
                     input logic st, fl, hl, input logic [2:0] a, b, input logic [31:0] cnt);
    row_t r;
    r.name = n; r.rs = rs; r.rt = rt; r.br = br; r.idrd = idrd; r.idwr = idwr; r.idmr = idmr;
    r.exrd = exrd; r.exwr = exwr; r.halt = halt; r.step = step;
    r.v = {st, fl, hl, a, b, cnt};
    stq.push_back(r);
  endtask
  task automatic set_idle();
    {i_ifid_rs, i_ifid_rt, i_idex_rd, i_exmem_rd} = '0;
    {i_id_branch, i_idex_regwrite, i_idex_memread, i_exmem_regwrite, i_halt_req, i_step} = '0;
  endtask
  task automatic drive_next();
    row_t r;
    exp_t e;
    r = stq.pop_front();
    @(posedge i_clk);
    #1;
    i_ifid_rs = r.rs; i_ifid_rt = r.rt; i_id_branch = r.br;
    i_idex_rd = r.idrd; i_idex_regwrite = r.idwr; i_idex_memread = r.idmr;
    i_exmem_rd = r.exrd; i_exmem_regwrite = r.exwr; i_halt_req = r.halt; i_step = r.step;
    e.name = r.name; e.v = r.v;
    sb.push_back(e);
  endtask
  task automatic do_reset();
    @(posedge i_clk);
    #1;
    set_idle();
    i_reset = 1'b0;
    #2;
    i_reset = 1'b1;
  endtask
  task automatic test_reset();
    i_reset = 1'b0;
    set_idle();
    #3;
    n_cmp++;
    if (obs !== 41'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", obs, 41'd0);
    end
    #4;
    i_reset = 1'b1;
  endtask
  task automatic test_alu_fwd();
    exp_t e;
    do_reset();
    add("fwd_ex_drive", 5,0,0, 5,1,0, 0,0, 0,0, 0,0,0, 3'b000,3'b000, 0);
    add("fwd_ex_A",     0,6,0, 0,0,0, 6,1, 0,0, 0,0,0, 3'b001,3'b000, 0);
    add("fwd_mem_B",    0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 3'b000,3'b010, 0);
    add("fwd_idle",     0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 3'b000,3'b000, 0);
    while (stq.size() > 0) begin
      drive_next();
      @(negedge i_clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: got %h want %h {stall,flush,halted,A,B,count}", e.name, obs, e.v);
      end
    end
  endtask
  task automatic test_priority();
    exp_t e;
    do_reset();
    add("prio_drive", 5,5,0, 5,1,0, 5,1, 0,0, 0,0,0, 3'b000,3'b000, 0);
    add("prio_exmem", 3,0,0, 3,0,0, 3,1, 0,0, 0,0,0, 3'b001,3'b001, 0);
    add("prio_memwb", 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 3'b010,3'b000, 0);
    add("prio_idle",  0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 3'b000,3'b000, 0);
    while (stq.size() > 0) begin
      drive_next();
      @(negedge i_clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: got %h want %h {stall,flush,halted,A,B,count}", e.name, obs, e.v);
      end
    end
  endtask
  task automatic test_load_use();
    exp_t e;
    do_reset();
    add("lu_bubble",    8,0,0, 8,1,1, 0,0, 0,0, 1,1,0, 3'b000,3'b000, 0);
    add("lu_resume",    8,0,0, 0,0,0, 8,1, 0,0, 0,0,0, 3'b000,3'b000, 1);
    add("lu_memwb_A",   0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 3'b010,3'b000, 1);
    add("lu_rt_bubble", 0,8,0, 8,1,1, 0,0, 0,0, 1,1,0, 3'b000,3'b000, 1);
    add("lu_rt_count",  0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 3'b000,3'b000, 2);
    while (stq.size() > 0) begin
      drive_next();
      @(negedge i_clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: got %h want %h {stall,flush,halted,A,B,count}", e.name, obs, e.v);
      end
    end
  endtask
  task automatic test_branch();
    exp_t e;
    do_reset();
    add("br2_cyc1",  9,0,1, 9,1,0, 0,0, 0,0, 1,1,0, 3'b000,3'b000, 0);
    add("br2_cyc2",  9,0,1, 0,0,0, 9,1, 0,0, 1,1,0, 3'b000,3'b000, 1);
    add("br2_done",  9,0,1, 0,0,0, 0,0, 0,0, 0,0,0, 3'b000,3'b000, 2);
    add("br1_cyc1",  0,4,1, 0,0,0, 4,1, 0,0, 1,1,0, 3'b000,3'b000, 2);
    add("br1_done",  0,4,1, 0,0,0, 0,0, 0,0, 0,0,0, 3'b000,3'b000, 3);
    add("br_idle",   0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 3'b000,3'b000, 3);
    while (stq.size() > 0) begin
      drive_next();
      @(negedge i_clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: got %h want %h {stall,flush,halted,A,B,count}", e.name, obs, e.v);
      end
    end
  endtask
  task automatic test_halt_step();
    exp_t e;
    do_reset();
    add("halt_req",     5,0,0, 5,1,0, 0,0, 1,0, 0,0,0, 3'b000,3'b000, 0);
    add("halt_enter",   7,0,0, 7,1,0, 0,0, 1,0, 1,0,1, 3'b001,3'b000, 0);
    add("halt_frozen",  7,0,0, 7,1,0, 0,0, 1,0, 1,0,1, 3'b001,3'b000, 0);
    add("halt_steppls", 0,7,0, 7,1,0, 0,0, 1,1, 1,0,1, 3'b001,3'b000, 0);
    add("step_cycle",   0,7,0, 7,1,0, 0,0, 1,0, 0,0,0, 3'b001,3'b000, 0);
    add("step_rehalt",  0,0,0, 0,0,0, 0,0, 1,0, 1,0,1, 3'b000,3'b001, 0);
    add("halt_release", 0,0,0, 0,0,0, 0,0, 0,0, 1,0,1, 3'b000,3'b001, 0);
    add("run_again",    0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 3'b000,3'b001, 0);
    add("defer_hazard", 8,0,0, 8,1,1, 0,0, 1,0, 1,1,0, 3'b000,3'b000, 0);
    add("defer_run",    0,0,0, 0,0,0, 8,1, 1,0, 0,0,0, 3'b000,3'b000, 1);
    add("defer_halted", 0,0,0, 0,0,0, 0,0, 1,0, 1,0,1, 3'b000,3'b000, 1);
    while (stq.size() > 0) begin
      drive_next();
      @(negedge i_clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: got %h want %h {stall,flush,halted,A,B,count}", e.name, obs, e.v);
      end
    end
    set_idle();
  endtask
  task automatic test_reset_r0();
    exp_t e;
    do_reset();
    add("rst_br_cyc1", 9,0,1, 9,1,0, 0,0, 0,0, 1,1,0, 3'b000,3'b000, 0);
    while (stq.size() > 0) begin
      drive_next();
      @(negedge i_clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: got %h want %h {stall,flush,halted,A,B,count}", e.name, obs, e.v);
      end
    end
    @(posedge i_clk);
    #1;
    set_idle();
    #1;
    n_cmp++;
    if ({o_stall, o_stall_count} !== {1'b1, 32'd1}) begin
      n_err++;
      $display("FAIL bstall_before_reset: got stall=%b count=%0d want stall=1 count=1", o_stall, o_stall_count);
    end
    i_reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 41'd0) begin
      n_err++;
      $display("FAIL reset_mid_bstall: got %h want %h", obs, 41'd0);
    end
    #1;
    i_reset = 1'b1;
    add("r0_no_stall", 0,0,1, 0,1,1, 0,1, 0,0, 0,0,0, 3'b000,3'b000, 0);
    add("r0_no_fwd",   0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 3'b000,3'b000, 0);
    while (stq.size() > 0) begin
      drive_next();
      @(negedge i_clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: got %h want %h {stall,flush,halted,A,B,count}", e.name, obs, e.v);
      end
    end
  endtask
  initial begin
    test_reset();
    test_alu_fwd();
    test_priority();
    test_load_use();
    test_branch();
    test_halt_step();
    test_reset_r0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
